// File: rtl/sublime_i2s_tx_pkg.sv
// Shared I2S transmitter defaults and helpers for the sublime audio path.
// LRCLK_LEFT is the word-select level that marks the left channel slot.
package sublime_i2s_tx_pkg;

  localparam int I2S_CLK_DIV = 4;
  localparam int I2S_SLOT_W  = 32;
  localparam int I2S_DATA_W  = 24;

  localparam logic LRCLK_LEFT = 1'b0;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sublime_i2s_clkgen.sv
// BCLK generator: divides clk by 2*CLK_DIV and flags the cycle whose edge
// drives BCLK low, which is the only edge the serialiser acts on.
module sublime_i2s_clkgen
  import sublime_i2s_tx_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic bclk,
  output logic fall_stb
);

  localparam int DW = cnt_w(CLK_DIV);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          term_cnt;

  assign term_cnt = (div_cnt_q == DW'(CLK_DIV - 1));

  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    if (!enable) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (term_cnt) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk     = bclk_q;
  assign fall_stb = enable & term_cnt & bclk_q;

endmodule

// File: rtl/sublime_i2s_tx.sv
// Philips I2S transmitter: latches a stereo frame at each frame start and
// shifts it out MSB first, one BCLK behind the word-select transition.
module sublime_i2s_tx
  import sublime_i2s_tx_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV,
  parameter int SLOT_W  = I2S_SLOT_W,
  parameter int DATA_W  = I2S_DATA_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] left_sample,
  input  logic [31:0] right_sample,
  input  logic        sample_valid,
  output logic        sample_ack,
  output logic        underrun,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BW      = cnt_w(FRAME_W);

  logic               fall_stb;
  logic               frame_start;
  logic [SLOT_W-1:0]  left_slot, right_slot;
  logic               unused_low_bits;

  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               lrclk_q, lrclk_d;
  logic               delay_q, delay_d;
  logic               sdata_q, sdata_d;
  logic               ack_q, ack_d;
  logic               underrun_q, underrun_d;

  sublime_i2s_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bclk     (i2s_bclk),
    .fall_stb (fall_stb)
  );

  assign frame_start     = fall_stb & (bit_cnt_q == BW'(FRAME_W - 1));
  assign unused_low_bits = ^{left_sample, right_sample};

  // Only the top DATA_W bits of each sample are sent; the rest of the slot is zero.
  always_comb begin
    left_slot                          = '0;
    right_slot                         = '0;
    left_slot[SLOT_W-1 -: DATA_W]  = left_sample[31 -: DATA_W];
    right_slot[SLOT_W-1 -: DATA_W] = right_sample[31 -: DATA_W];
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    lrclk_d    = lrclk_q;
    delay_d    = delay_q;
    sdata_d    = sdata_q;
    ack_d      = 1'b0;
    underrun_d = 1'b0;
    if (!enable) begin
      bit_cnt_d = BW'(FRAME_W - 1);
      shreg_d   = '0;
      lrclk_d   = 1'b0;
      delay_d   = 1'b0;
      sdata_d   = 1'b0;
    end else if (fall_stb) begin
      bit_cnt_d = frame_start ? '0 : bit_cnt_q + 1'b1;
      lrclk_d   = (bit_cnt_d >= BW'(SLOT_W)) ? ~LRCLK_LEFT : LRCLK_LEFT;
      if (frame_start) begin
        shreg_d    = sample_valid ? {left_slot, right_slot} : '0;
        ack_d      = sample_valid;
        underrun_d = ~sample_valid;
      end else begin
        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
      end
      // The delay bit takes the post-load MSB so the left MSB lands at bit_cnt=1.
      sdata_d = delay_q;
      delay_d = shreg_d[FRAME_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= BW'(FRAME_W - 1);
      shreg_q    <= '0;
      lrclk_q    <= 1'b0;
      delay_q    <= 1'b0;
      sdata_q    <= 1'b0;
      ack_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      lrclk_q    <= lrclk_d;
      delay_q    <= delay_d;
      sdata_q    <= sdata_d;
      ack_q      <= ack_d;
      underrun_q <= underrun_d;
    end
  end

  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;
  assign sample_ack = ack_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_sublime_i2s_tx.sv
// Bench for sublime_i2s_tx: two instances (2/32/24 and 1/16/16) checked every
// cycle against a time-based frame model, plus directed literal expectations.
module tb_sublime_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en [2];
  logic        sv [2];
  logic [31:0] ls [2];
  logic [31:0] rs [2];
  logic        bclk0, lr0, sd0, ack0, un0;
  logic        bclk1, lr1, sd1, ack1, un1;

  int  errors = 0;
  int  checks = 0;
  bit  rand_on = 1'b0;

  // Model state: enabled-clock count per instance, and the last two latched frames.
  int          mt [2];
  bit          mv [2][2];
  logic [31:0] ml [2][2];
  logic [31:0] mr [2][2];

  always #5 clk = ~clk;

  sublime_i2s_tx #(.CLK_DIV(2), .SLOT_W(32), .DATA_W(24)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]),
    .left_sample(ls[0]), .right_sample(rs[0]), .sample_valid(sv[0]),
    .sample_ack(ack0), .underrun(un0),
    .i2s_bclk(bclk0), .i2s_lrclk(lr0), .i2s_sdata(sd0)
  );

  sublime_i2s_tx #(.CLK_DIV(1), .SLOT_W(16), .DATA_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]),
    .left_sample(ls[1]), .right_sample(rs[1]), .sample_valid(sv[1]),
    .sample_ack(ack1), .underrun(un1),
    .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_sdata(sd1)
  );

  function automatic int cdiv(input int d);  return (d != 0) ? 1 : 2;   endfunction
  function automatic int slotw(input int d); return (d != 0) ? 16 : 32; endfunction
  function automatic int dataw(input int d); return (d != 0) ? 16 : 24; endfunction

  // {bclk, lrclk, sdata, ack, underrun}
  function automatic logic [4:0] get_out(input int d);
    return (d != 0) ? {bclk1, lr1, sd1, ack1, un1} : {bclk0, lr0, sd0, ack0, un0};
  endfunction

  // Transmitted bit j (0 = first on the wire) of a stored frame.
  function automatic logic stream_bit(input int d, input int k, input int j);
    int          s;
    int          pos;
    logic [31:0] w;
    if (!mv[d][k]) return 1'b0;
    s   = j / slotw(d);
    pos = j % slotw(d);
    if (pos >= dataw(d)) return 1'b0;
    w = (s != 0) ? mr[d][k] : ml[d][k];
    return w[31 - pos];
  endfunction

  // Outputs after t enabled clocks: f falling BCLKs have happened, the
  // f-th fall starts bit (f-1) mod frame, and sdata lags the stream by one bit.
  function automatic logic [4:0] model_out(input int d);
    int   p2, fr, t, f, bc, k;
    logic b, lr, sd, ak, un;
    p2 = 2 * cdiv(d);
    fr = 2 * slotw(d);
    t  = mt[d];
    b  = ((t / cdiv(d)) % 2) == 1;
    f  = t / p2;
    lr = 1'b0; sd = 1'b0; ak = 1'b0; un = 1'b0;
    if (f >= 1) begin
      bc = (f - 1) % fr;
      k  = ((f - 1) / fr) % 2;
      lr = (bc >= slotw(d));
      if ((t % p2) == 0 && bc == 0) begin
        ak = mv[d][k];
        un = !mv[d][k];
      end
      if (f >= 2) sd = stream_bit(d, ((f - 2) / fr) % 2, (f - 2) % fr);
    end
    return {b, lr, sd, ak, un};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || !en[d]) begin
        mt[d] = 0;
      end else begin
        mt[d] = mt[d] + 1;
        if ((mt[d] % (2 * cdiv(d))) == 0) begin
          int f;
          int k;
          f = mt[d] / (2 * cdiv(d));
          if (((f - 1) % (2 * slotw(d))) == 0) begin
            k = ((f - 1) / (2 * slotw(d))) % 2;
            mv[d][k] = sv[d];
            ml[d][k] = ls[d];
            mr[d][k] = rs[d];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [4:0] got;
      logic [4:0] exp;
      got = get_out(d);
      exp = model_out(d);
      checks++;
      if (got !== exp) begin
        errors++;
        if (errors < 40)
          $display("FAIL model_dut%0d t=%0d got {bclk,lr,sd,ack,un}=%b expected %b", d, mt[d], got, exp);
      end
    end
  end

  // Random producer: holds a valid frame until acked, sometimes offers nothing.
  always @(negedge clk) begin
    if (rand_on) begin
      for (int d = 0; d < 2; d++) begin
        logic [4:0] o;
        o = get_out(d);
        if (o[1] || !sv[d]) begin
          sv[d] = ($urandom_range(0, 3) != 0);
          ls[d] = $urandom;
          rs[d] = $urandom;
        end
        en[d] = ($urandom_range(0, 799) != 0);
      end
    end
  end

  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int d);
    en[d] = 1'b0;
    wait_neg(2);
  endtask

  // Enable from idle and check the first handshake pulse lands 2*CLK_DIV clocks later.
  task automatic start_frame(input int d, input string tag, input logic [1:0] pulse);
    logic [4:0] o;
    en[d] = 1'b1;
    wait_neg(2 * cdiv(d) - 1);
    o = get_out(d);
    lit({tag, " no pulse before first fall"}, o[1:0], 2'b00);
    wait_neg(1);
    o = get_out(d);
    lit({tag, " first {ack,underrun}"}, o[1:0], pulse);
  endtask

  // Collect one frame of sdata, one bit per BCLK, starting at a frame start.
  task automatic capture(input int d, output logic [63:0] w, output int lr_hi);
    logic [4:0] o;
    w = '0;
    lr_hi = 0;
    for (int j = 0; j < 2 * slotw(d); j++) begin
      wait_neg(2 * cdiv(d));
      o = get_out(d);
      w = {w[62:0], o[2]};
      lr_hi += int'(o[3]);
    end
  endtask

  initial begin
    logic [63:0] w;
    int          lh;
    logic [4:0]  o;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; sv[d] = 1'b0; ls[d] = '0; rs[d] = '0;
    end
    wait_neg(3);
    lit("reset outputs dut0", 64'(get_out(0)), 64'h0);
    lit("reset outputs dut1", 64'(get_out(1)), 64'h0);
    rst_n = 1'b1;
    wait_neg(100);
    lit("idle outputs dut0", 64'(get_out(0)), 64'h0);

    sv[0] = 1'b1; ls[0] = 32'hA5A5_5A00; rs[0] = 32'h8000_0100;
    start_frame(0, "frame", 2'b10);
    capture(0, w, lh);
    lit("frame decoded bits", w, 64'hA5A55A00_80000100);
    lit("frame lrclk high bclks", 64'(lh), 64'd32);
    o = get_out(0);
    lit("frame next ack after 256 clk", 64'(o[1:0]), 64'(2'b10));
    idle(0);

    ls[0] = 32'h8000_0000; rs[0] = 32'h0;
    start_frame(0, "align", 2'b10);
    capture(0, w, lh);
    lit("align only bit_cnt=1 high", w, 64'h80000000_00000000);
    idle(0);

    sv[0] = 1'b0;
    start_frame(0, "underrun", 2'b01);
    sv[0] = 1'b1; ls[0] = 32'h1234_5600; rs[0] = 32'hABCD_EF00;
    capture(0, w, lh);
    lit("underrun frame all zero", w, 64'h0);
    o = get_out(0);
    lit("after underrun ack", 64'(o[1:0]), 64'(2'b10));
    capture(0, w, lh);
    lit("after underrun data", w, 64'h12345600_ABCDEF00);

    wait_neg(40 * 4);
    en[0] = 1'b0;
    wait_neg(1);
    lit("abort outputs next cycle", 64'(get_out(0)), 64'h0);
    wait_neg(5);
    lit("abort outputs stay low", 64'(get_out(0)), 64'h0);
    start_frame(0, "restart", 2'b10);
    capture(0, w, lh);
    lit("restart frame from bit 0", w, 64'h12345600_ABCDEF00);
    idle(0);

    sv[1] = 1'b1; ls[1] = 32'hA5A5_5A00; rs[1] = 32'h8000_0100;
    start_frame(1, "small frame", 2'b10);
    capture(1, w, lh);
    lit("small frame decoded bits", w, 64'hA5A58000);
    lit("small frame lrclk high bclks", 64'(lh), 64'd16);
    o = get_out(1);
    lit("small frame next ack after 64 clk", 64'(o[1:0]), 64'(2'b10));
    idle(1);

    rand_on = 1'b1;
    wait_neg(3000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    lit("async reset dut0 immediate", 64'(get_out(0)), 64'h0);
    lit("async reset dut1 immediate", 64'(get_out(1)), 64'h0);
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(5000);
    rand_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
